// File: rtl/sa_cache_miss_ctrl.sv
// Miss sequencer for sa_cache: optional victim writeback, line fetch, fill pulse.
// Define MISS_CTRL_STATS_EN to add saturating miss/writeback counters.
module sa_cache_miss_ctrl #(
   parameter int TAG_W    = 18,
   parameter int INDEX_W  = 8,
   parameter int OFFSET_W = 6,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cache_miss,
   input  logic              i_evict,
   input  logic [ADDR_W-1:0] i_evict_addr,
   input  logic [DATA_W-1:0] i_evict_data,
   input  logic [TAG_W-1:0]  i_miss_tag,
   input  logic [INDEX_W-1:0] i_miss_index,
   output logic              o_stall,
   output logic [DATA_W-1:0] o_fill_data,
   output logic              o_fill_valid,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ready,
   input  logic              i_mem_rvalid,
   input  logic [DATA_W-1:0] i_mem_rdata
`ifdef MISS_CTRL_STATS_EN
   ,
   output logic [31:0]       o_miss_count,
   output logic [31:0]       o_wb_count
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      WB_REQ,
      RD_REQ,
      RD_WAIT,
      FILL,
      RESUME
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] line_addr_q;
   logic [ADDR_W-1:0] evict_addr_q;
   logic [DATA_W-1:0] evict_data_q;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] fill_data_q;
   logic              fill_valid_q;
   logic [ADDR_W-1:0] miss_line;
   logic              miss_accept;
   logic              wb_accept;

   assign miss_line   = {i_miss_tag, i_miss_index, {OFFSET_W{1'b0}}};
   assign miss_accept = (state_q == IDLE) && i_cache_miss;
   assign wb_accept   = (state_q == WB_REQ) && i_mem_ready;

   // Combinational so a hit following a completed miss sees no bubble
   assign o_stall      = (state_q != IDLE) | i_cache_miss;
   assign o_fill_data  = fill_data_q;
   assign o_fill_valid = fill_valid_q;
   assign o_mem_req    = req_q;
   assign o_mem_we     = we_q;
   assign o_mem_addr   = addr_q;
   assign o_mem_wdata  = wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         line_addr_q  <= '0;
         evict_addr_q <= '0;
         evict_data_q <= '0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         fill_data_q  <= '0;
         fill_valid_q <= 1'b0;
      end else begin
         fill_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_cache_miss) begin
                  line_addr_q <= miss_line;
                  req_q       <= 1'b1;
                  if (i_evict) begin
                     evict_addr_q <= i_evict_addr;
                     evict_data_q <= i_evict_data;
                     we_q         <= 1'b1;
                     addr_q       <= i_evict_addr;
                     wdata_q      <= i_evict_data;
                     state_q      <= WB_REQ;
                  end else begin
                     we_q    <= 1'b0;
                     addr_q  <= miss_line;
                     state_q <= RD_REQ;
                  end
               end
            end
            WB_REQ: begin
               // Read command follows back-to-back; req stays high
               if (i_mem_ready) begin
                  we_q    <= 1'b0;
                  addr_q  <= line_addr_q;
                  state_q <= RD_REQ;
               end
            end
            RD_REQ: begin
               if (i_mem_ready) begin
                  req_q   <= 1'b0;
                  state_q <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (i_mem_rvalid) begin
                  fill_data_q  <= i_mem_rdata;
                  fill_valid_q <= 1'b1;
                  state_q      <= FILL;
               end
            end
            FILL: begin
               state_q <= RESUME;
            end
            RESUME: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef MISS_CTRL_STATS_EN
   logic [31:0] miss_cnt_q;
   logic [31:0] wb_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         if (miss_accept && (miss_cnt_q != 32'hFFFF_FFFF))
            miss_cnt_q <= miss_cnt_q + 32'd1;
         if (wb_accept && (wb_cnt_q != 32'hFFFF_FFFF))
            wb_cnt_q <= wb_cnt_q + 32'd1;
      end
   end

   assign o_miss_count = miss_cnt_q;
   assign o_wb_count   = wb_cnt_q;
`else
   logic unused_acc;
   assign unused_acc = miss_accept ^ wb_accept ^ (|evict_addr_q) ^ (|evict_data_q);
`endif

endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// Scoreboard bench for sa_cache_miss_ctrl: directed misses, monitor checks
// memory commands and fill pulses against queued expectations.
module tb_sa_cache_miss_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_cache_miss;
   logic        i_evict;
   logic [31:0] i_evict_addr;
   logic [31:0] i_evict_data;
   logic [17:0] i_miss_tag;
   logic [7:0]  i_miss_index;
   logic        o_stall;
   logic [31:0] o_fill_data;
   logic        o_fill_valid;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ready;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
`ifdef MISS_CTRL_STATS_EN
   logic [31:0] o_miss_count;
   logic [31:0] o_wb_count;
`endif

   sa_cache_miss_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .i_cache_miss (i_cache_miss),
      .i_evict      (i_evict),
      .i_evict_addr (i_evict_addr),
      .i_evict_data (i_evict_data),
      .i_miss_tag   (i_miss_tag),
      .i_miss_index (i_miss_index),
      .o_stall      (o_stall),
      .o_fill_data  (o_fill_data),
      .o_fill_valid (o_fill_valid),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_ready  (i_mem_ready),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata)
`ifdef MISS_CTRL_STATS_EN
      ,
      .o_miss_count (o_miss_count),
      .o_wb_count   (o_wb_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   cmd_t        cmd_q[$];
   logic [31:0] fill_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations on accepted commands and fill pulses
   logic pend = 1'b0;
   cmd_t prev;
   cmd_t ec;
   logic [31:0] ef;
   always @(negedge clk) begin
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("hold_req", {31'd0, o_mem_req}, 32'd1);
            chk("hold_we", {31'd0, o_mem_we}, {31'd0, prev.we});
            chk("hold_addr", o_mem_addr, prev.addr);
            chk("hold_wdata", o_mem_wdata, prev.wdata);
         end
         pend = o_mem_req && !i_mem_ready;
         prev = '{we: o_mem_we, addr: o_mem_addr, wdata: o_mem_wdata};
         if (o_mem_req && i_mem_ready) begin
            n_cmp++;
            if (cmd_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexp_cmd: got we=%b addr=%h expected none",
                        o_mem_we, o_mem_addr);
            end else begin
               ec = cmd_q.pop_front();
               chk("cmd_we", {31'd0, o_mem_we}, {31'd0, ec.we});
               chk("cmd_addr", o_mem_addr, ec.addr);
               if (ec.we)
                  chk("cmd_wdata", o_mem_wdata, ec.wdata);
            end
         end
         if (o_fill_valid) begin
            n_cmp++;
            if (fill_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexp_fill: got %h expected none", o_fill_data);
            end else begin
               ef = fill_q.pop_front();
               chk("fill_data", o_fill_data, ef);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_miss(input logic [17:0] tag, input logic [7:0] idx,
                          input logic ev, input logic [31:0] ea,
                          input logic [31:0] ed, input logic [31:0] rd,
                          input int wbw, input int rdw, input bit spur);
      logic [31:0] line;
      line = {tag, idx, 6'b0};
      if (ev)
         cmd_q.push_back('{we: 1'b1, addr: ea, wdata: ed});
      cmd_q.push_back('{we: 1'b0, addr: line, wdata: 32'd0});
      fill_q.push_back(rd);
      tick();
      i_cache_miss = 1'b1;
      i_evict = ev;
      i_evict_addr = ea;
      i_evict_data = ed;
      i_miss_tag = tag;
      i_miss_index = idx;
      #1;
      chk("stall_comb", {31'd0, o_stall}, 32'd1);
      tick();
      i_cache_miss = 1'b0;
      i_evict = 1'b0;
      if (ev) begin
         i_mem_ready = 1'b0;
         repeat (wbw) tick();
         i_mem_ready = 1'b1;
         tick();
      end
      i_mem_ready = 1'b0;
      if (spur) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata = 32'hBAD0BAD0;
      end
      repeat (rdw) tick();
      i_mem_ready = 1'b1;
      i_mem_rvalid = 1'b0;
      tick();
      i_mem_ready = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata = rd;
      tick();
      i_mem_rvalid = 1'b0;
      i_mem_rdata = 32'd0;
      chk("fill_stall", {31'd0, o_stall}, 32'd1);
      chk("fill_pulse", {31'd0, o_fill_valid}, 32'd1);
      tick();
      chk("resume_stall", {31'd0, o_stall}, 32'd1);
      chk("resume_pulse", {31'd0, o_fill_valid}, 32'd0);
      tick();
      chk("idle_stall", {31'd0, o_stall}, 32'd0);
      chk("idle_req", {31'd0, o_mem_req}, 32'd0);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
      chk({tag, "_req"}, {31'd0, o_mem_req}, 32'd0);
      chk({tag, "_we"}, {31'd0, o_mem_we}, 32'd0);
      chk({tag, "_addr"}, o_mem_addr, 32'd0);
      chk({tag, "_wdata"}, o_mem_wdata, 32'd0);
      chk({tag, "_fdata"}, o_fill_data, 32'd0);
      chk({tag, "_fvalid"}, {31'd0, o_fill_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      i_cache_miss = 1'b0;
      i_evict = 1'b0;
      i_evict_addr = 32'd0;
      i_evict_data = 32'd0;
      i_miss_tag = 18'd0;
      i_miss_index = 8'd0;
      i_mem_ready = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata = 32'd0;
      repeat (3) tick();
      chk_reset_outs("rst0");
      rst = 1'b0;
      tick();

      // Clean miss; expected read address hand-computed
      cmd_q.push_back('{we: 1'b0, addr: 32'h02AF0480, wdata: 32'd0});
      fill_q.push_back(32'hDEADBEEF);
      tick();
      i_cache_miss = 1'b1;
      i_miss_tag = 18'h00ABC;
      i_miss_index = 8'h12;
      tick();
      i_cache_miss = 1'b0;
      chk("clean_rdreq", {31'd0, o_mem_req}, 32'd1);
      i_mem_ready = 1'b1;
      tick();
      i_mem_ready = 1'b0;
      chk("clean_wait_req", {31'd0, o_mem_req}, 32'd0);
      i_mem_rvalid = 1'b1;
      i_mem_rdata = 32'hDEADBEEF;
      tick();
      i_mem_rvalid = 1'b0;
      chk("clean_fill", {31'd0, o_fill_valid}, 32'd1);
      tick();
      chk("clean_resume", {31'd0, o_stall}, 32'd1);
      tick();
      chk("clean_idle", {31'd0, o_stall}, 32'd0);

      // Dirty miss, no backpressure
      do_miss(18'h3FFFF, 8'hFF, 1'b1, 32'h00001040, 32'h12345678,
              32'hCAFEF00D, 0, 0, 1'b0);
      // Backpressure: 3 cycles in WB_REQ, 2 in RD_REQ, rvalid noise in RD_REQ
      do_miss(18'h00001, 8'h00, 1'b1, 32'hA5A5A5C0, 32'h0F0F0F0F,
              32'h13579BDF, 3, 2, 1'b1);
      do_miss(18'h2AAAA, 8'h55, 1'b0, 32'hFFFFFFC0, 32'hFFFFFFFF,
              32'h00000001, 0, 2, 1'b1);

      // Spurious inputs in IDLE
      i_mem_rvalid = 1'b1;
      i_mem_rdata = 32'h55AA55AA;
      i_mem_ready = 1'b1;
      i_evict = 1'b1;
      i_evict_addr = 32'h00002000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("spur_req", {31'd0, o_mem_req}, 32'd0);
         chk("spur_stall", {31'd0, o_stall}, 32'd0);
      end
      i_mem_rvalid = 1'b0;
      i_mem_ready = 1'b0;
      i_evict = 1'b0;

      // Reset while in RD_WAIT
      cmd_q.push_back('{we: 1'b0, addr: {18'h01234, 8'h56, 6'b0},
                        wdata: 32'd0});
      tick();
      i_cache_miss = 1'b1;
      i_miss_tag = 18'h01234;
      i_miss_index = 8'h56;
      tick();
      i_cache_miss = 1'b0;
      i_mem_ready = 1'b1;
      tick();
      i_mem_ready = 1'b0;
      chk("rw_stall", {31'd0, o_stall}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outs("rst_mid");
      for (int i = 0; i < 2; i++) begin
         i_mem_ready = ~i_mem_ready;
         i_mem_rvalid = ~i_mem_rvalid;
         i_mem_rdata = 32'hFEEDFACE;
         tick();
      end
      chk_reset_outs("rst_tog");
`ifdef MISS_CTRL_STATS_EN
      chk("rst_miss_cnt", o_miss_count, 32'd0);
      chk("rst_wb_cnt", o_wb_count, 32'd0);
`endif
      i_mem_ready = 1'b0;
      i_mem_rvalid = 1'b1;
      rst = 1'b0;
      tick();
      tick();
      i_mem_rvalid = 1'b0;
      chk("stale_fvalid", {31'd0, o_fill_valid}, 32'd0);
      chk("stale_stall", {31'd0, o_stall}, 32'd0);

      do_miss(18'h00100, 8'h01, 1'b0, 32'd0, 32'd0, 32'h11111111, 0, 0, 1'b0);
      do_miss(18'h00200, 8'h02, 1'b1, 32'h00003000, 32'h22222222,
              32'h33333333, 1, 1, 1'b0);
`ifdef MISS_CTRL_STATS_EN
      chk("miss_cnt", o_miss_count, 32'd2);
      chk("wb_cnt", o_wb_count, 32'd1);
`endif

      repeat (3) tick();
      chk("cmd_left", cmd_q.size(), 32'd0);
      chk("fill_left", fill_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sa_cache_miss_ctrl.md
Name: sa_cache_miss_ctrl

Overview:
Miss-handling sequencer between the 4-way set-associative cache (sa_cache) and the backing memory bus. On a cache miss it stalls the requester, writes back the evicted line if the cache flags an eviction, and fetches the missing line. It then delivers the line to the cache's memory-line/response inputs and releases the stall. The block is one instance per cache and has a single outstanding miss.

Parameters:
TAG_W, 18, tag field width
INDEX_W, 8, set index width
OFFSET_W, 6, byte offset width; the line address has the offset field zeroed
DATA_W, 32, line/data width transferred per memory beat
ADDR_W, 32, memory address width; must equal TAG_W+INDEX_W+OFFSET_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
i_cache_miss  in  1  cache miss flag from sa_cache
i_evict  in  1  miss requires writeback of victim line
i_evict_addr  in  ADDR_W  victim line address
i_evict_data  in  DATA_W  victim line data
i_miss_tag  in  TAG_W  tag of missing access
i_miss_index  in  INDEX_W  index of missing access
o_stall  out  1  hold requester/pipeline
o_fill_data  out  DATA_W  line to cache i_memory_line
o_fill_valid  out  1  one-cycle pulse to cache i_memory_response
o_mem_req  out  1  memory command valid
o_mem_we  out  1  1=write, 0=read
o_mem_addr  out  ADDR_W  command address
o_mem_wdata  out  DATA_W  write data
i_mem_ready  in  1  command accepted this cycle when high with o_mem_req
i_mem_rvalid  in  1  read data valid
i_mem_rdata  in  DATA_W  read data

Behaviour:
- Reset: state IDLE. o_stall, o_fill_valid, o_mem_req, o_mem_we = 0. o_mem_addr, o_mem_wdata, o_fill_data = 0. All latched miss info = 0.
- o_stall = (state != IDLE) | i_cache_miss (combinational, so no hit-path bubble).
- IDLE: when i_cache_miss=1, latch line_addr = {i_miss_tag, i_miss_index, OFFSET_W'b0}. Latch i_evict_addr/i_evict_data if i_evict. Next state is WB_REQ if i_evict=1, else RD_REQ. i_evict without i_cache_miss is ignored.
- WB_REQ: o_mem_req=1, o_mem_we=1, o_mem_addr=latched evict addr, o_mem_wdata=latched evict data. Go to RD_REQ on i_mem_ready.
- RD_REQ: o_mem_req=1, o_mem_we=0, o_mem_addr=line_addr. Go to RD_WAIT on i_mem_ready.
- RD_WAIT: on i_mem_rvalid, register i_mem_rdata into o_fill_data and go to FILL. Ready and rvalid arriving in the same cycle is not possible, since rvalid is only sampled in RD_WAIT.
- FILL: o_fill_valid=1 for exactly one cycle, with o_fill_data stable. Go to RESUME.
- RESUME: stall held; i_cache_miss ignored for one cycle while the cache updates. Go to IDLE.
- Command rules: o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata are registered and held stable until accepted. The request is never withdrawn. o_mem_req is deasserted the cycle after acceptance unless the next command issues immediately (WB_REQ to RD_REQ leaves req high; addr and we change).
- i_mem_rvalid outside RD_WAIT is ignored. This includes a stale response after a reset.
- i_mem_ready outside WB_REQ/RD_REQ is ignored.
- Latency, no eviction, ready=1, rvalid 1 cycle after accept: miss seen at cycle 0, RD_REQ at 1, RD_WAIT at 2, FILL at 3, RESUME at 4, IDLE at 5.
- An eviction adds one cycle plus any ready wait.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The in-flight memory transaction is abandoned.
- A miss arriving at a new address while busy is impossible (requester is stalled) and is ignored.

Optional Feature:
MISS_CTRL_STATS_EN. When defined, the block adds outputs o_miss_count[31:0] and o_wb_count[31:0].
- o_miss_count increments on each IDLE miss acceptance.
- o_wb_count increments on each accepted writeback command.
- Both saturate at 0xFFFFFFFF and reset to 0.

When the macro is undefined, these ports and their counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 mid-sim, toggling memory inputs -> all outputs 0, state IDLE, o_stall=0 with i_cache_miss=0.
- Clean miss: tag=18'h00ABC, index=8'h12, i_evict=0, ready=1, rvalid one cycle later with rdata=32'hDEADBEEF -> read cmd addr=32'h02AF0480, we=0; o_fill_valid one-cycle pulse with data 32'hDEADBEEF; o_stall high through RESUME; IDLE after 5 cycles.
- Dirty miss: i_evict=1, evict_addr=32'h00001040, evict_data=32'h12345678 -> write cmd first with exactly those values and we=1, then the read cmd, then the fill.
- Backpressure: i_mem_ready low for 3 cycles in WB_REQ and 2 in RD_REQ -> addr/wdata/we stable throughout, no fill until rvalid, exactly one write and one read accepted.
- Spurious inputs: rvalid=1 in IDLE and in RD_REQ, evict=1 without miss -> no state change, no fill pulse.
- Reset in RD_WAIT, then rvalid=1 after release -> no fill pulse; with MISS_CTRL_STATS_EN, o_miss_count=0 after reset, and two subsequent misses (one dirty) give o_miss_count=2, o_wb_count=1.
